lieat_wb_arbiter: RTL and testbench
===================================

Name: lieat_wb_arbiter

Overview:
- Sequences the single register-file write port between three write-back sources:
  - EXU in-order results.
  - LSU load returns.
  - Long-latency instructions (MUL/DIV), which return results in issue order.
- Keeps a small in-order queue of outstanding long-instruction rd/pc and a scoreboard so EXU can detect RAW hazards on pending destinations.
- Drives the regfile wb_* inputs from a registered write-back stage, including the wb_lsu and longi_empty difftest signals.

Parameters:
XLEN, 32, data/pc width
RGIDX_SIZE, 5, register index width
LQ_DEPTH, 4, long-instruction queue entries (power of 2)
STARVE_MAX, 3, consecutive denied cycles before longi wins top priority

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exu_wb_valid  in  1  EXU result request
exu_wb_ready  out  1  EXU granted this cycle
exu_wb_en  in  1  EXU writes rd
exu_wb_rd  in  RGIDX_SIZE  EXU destination
exu_wb_data  in  XLEN  EXU result
exu_wb_pc  in  XLEN  EXU pc
lsu_wb_valid  in  1  LSU load-return request
lsu_wb_ready  out  1  LSU granted
lsu_wb_en  in  1  LSU writes rd
lsu_wb_rd  in  RGIDX_SIZE  LSU destination
lsu_wb_data  in  XLEN  load data
lsu_wb_pc  in  XLEN  LSU pc
longi_issue_valid  in  1  long instruction dispatched
longi_issue_ready  out  1  queue can accept
longi_issue_rd  in  RGIDX_SIZE  long-instruction destination
longi_issue_pc  in  XLEN  long-instruction pc
longi_wb_valid  in  1  long result ready (oldest outstanding)
longi_wb_ready  out  1  long result granted
longi_wb_data  in  XLEN  long result
exu_rs1  in  RGIDX_SIZE  scoreboard query 1
exu_rs2  in  RGIDX_SIZE  scoreboard query 2
exu_rs1_busy  out  1  rs1 has a pending write
exu_rs2_busy  out  1  rs2 has a pending write
wb_valid  out  1  registered write-back valid (one retire)
wb_en  out  1  regfile write enable
wb_rd  out  RGIDX_SIZE  regfile write index
wb_data  out  XLEN  regfile write data
wb_pc  out  XLEN  retiring pc
wb_lsu  out  1  entry came from LSU
longi_empty  out  1  no long instruction outstanding in queue

Behaviour:
- Reset (rst=1 at posedge):
  - wb_valid, wb_en, wb_rd, wb_data, wb_pc, wb_lsu = 0.
  - Queue emptied (pointers/count 0), so longi_empty=1.
  - Starvation counter = 0.
  - Busy outputs = 0.
  - Reset mid-operation discards queued entries and the wb stage.
- Arbitration (combinational grant, one grant per cycle):
  - Normal priority: lsu > longi > exu.
  - If starve_cnt == STARVE_MAX and longi_wb_valid=1, longi takes top priority.
  - Each ready output = that source's grant; a source is consumed on valid&ready.
  - longi_wb_ready=0 whenever the queue is empty. longi_wb_valid on an empty queue is ignored and does not affect starve_cnt.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle longi_wb_valid=1 and is not granted.
  - Cleared on longi grant, or when longi_wb_valid=0.
- Write-back stage (latency 1): on a grant, the next posedge loads:
  - wb_valid=1.
  - wb_en = src_en & (rd != 0).
  - wb_rd/wb_data/wb_pc from the source.
  - For longi: rd and pc come from the queue head, data from longi_wb_data.
  - wb_lsu = 1 iff the source is LSU.
  - With no grant, wb_valid=0 and wb_en=0 next cycle; rd/data/pc hold.
- Long-instruction queue:
  - FIFO of {rd, pc}, LQ_DEPTH entries.
  - Push on longi_issue_valid & longi_issue_ready.
  - longi_issue_ready = !full. No same-cycle pop bypass when full.
  - Pop on longi grant.
  - Simultaneous push and pop when not full: count unchanged, pointers wrap modulo LQ_DEPTH.
  - longi_empty = (count == 0).
- Scoreboard (combinational):
  - exu_rsN_busy = (rsN != 0) & (any valid queue entry rd == rsN, or wb_valid & wb_en & wb_rd == rsN).
  - Multiple queue entries with the same rd are allowed; busy stays set until the last one drains.
  - Busy reflects state before this cycle's push.

Test Plan:
- Reset, then exu_wb_valid with rd=5, data=0x1234, pc=0x80000000 -> exu_wb_ready=1; next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x1234, wb_lsu=0.
- LSU (rd=3) and EXU (rd=4) valid in the same cycle -> lsu granted first with wb_lsu=1, exu the following cycle, both retire in consecutive cycles.
- Issue longi rd=7 pc=0x100 -> longi_empty=0 and exu_rs1=7 gives busy=1. longi_wb_valid data=0xDEAD -> wb_rd=7, wb_pc=0x100, wb_data=0xDEAD. Busy stays set through the wb cycle, then clears; longi_empty=1.
- longi_wb_valid held while lsu_wb_valid is continuous -> longi denied for 3 cycles, then granted on the 4th, then starve_cnt resets.
- Issue 4 long instructions -> longi_issue_ready=0 on the 5th. Interleave pop and push for 8 cycles -> queue wraps, results retire in issue order with the correct pcs.
- EXU write to rd=0 -> wb_valid=1, wb_en=0. Querying rs1=0 -> busy=0. Assert rst with 2 queued entries -> longi_empty=1 and busy=0 the next cycle.

Source files
------------

// File: rtl/lieat_wb_arbiter_if.sv
// rtl/lieat_wb_arbiter_if.sv - write-back sources, long-instruction issue, scoreboard query and regfile write port
interface lieat_wb_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int RGIDX_SIZE = 5
);
  logic                  exu_wb_valid;
  logic                  exu_wb_ready;
  logic                  exu_wb_en;
  logic [RGIDX_SIZE-1:0] exu_wb_rd;
  logic [XLEN-1:0]       exu_wb_data;
  logic [XLEN-1:0]       exu_wb_pc;

  logic                  lsu_wb_valid;
  logic                  lsu_wb_ready;
  logic                  lsu_wb_en;
  logic [RGIDX_SIZE-1:0] lsu_wb_rd;
  logic [XLEN-1:0]       lsu_wb_data;
  logic [XLEN-1:0]       lsu_wb_pc;

  logic                  longi_issue_valid;
  logic                  longi_issue_ready;
  logic [RGIDX_SIZE-1:0] longi_issue_rd;
  logic [XLEN-1:0]       longi_issue_pc;
  logic                  longi_wb_valid;
  logic                  longi_wb_ready;
  logic [XLEN-1:0]       longi_wb_data;

  logic [RGIDX_SIZE-1:0] exu_rs1;
  logic [RGIDX_SIZE-1:0] exu_rs2;
  logic                  exu_rs1_busy;
  logic                  exu_rs2_busy;

  logic                  wb_valid;
  logic                  wb_en;
  logic [RGIDX_SIZE-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [XLEN-1:0]       wb_pc;
  logic                  wb_lsu;
  logic                  longi_empty;

  modport master (
    output exu_wb_valid, exu_wb_en, exu_wb_rd, exu_wb_data, exu_wb_pc,
    output lsu_wb_valid, lsu_wb_en, lsu_wb_rd, lsu_wb_data, lsu_wb_pc,
    output longi_issue_valid, longi_issue_rd, longi_issue_pc,
    output longi_wb_valid, longi_wb_data, exu_rs1, exu_rs2,
    input  exu_wb_ready, lsu_wb_ready, longi_issue_ready, longi_wb_ready,
    input  exu_rs1_busy, exu_rs2_busy,
    input  wb_valid, wb_en, wb_rd, wb_data, wb_pc, wb_lsu, longi_empty
  );

  modport slave (
    input  exu_wb_valid, exu_wb_en, exu_wb_rd, exu_wb_data, exu_wb_pc,
    input  lsu_wb_valid, lsu_wb_en, lsu_wb_rd, lsu_wb_data, lsu_wb_pc,
    input  longi_issue_valid, longi_issue_rd, longi_issue_pc,
    input  longi_wb_valid, longi_wb_data, exu_rs1, exu_rs2,
    output exu_wb_ready, lsu_wb_ready, longi_issue_ready, longi_wb_ready,
    output exu_rs1_busy, exu_rs2_busy,
    output wb_valid, wb_en, wb_rd, wb_data, wb_pc, wb_lsu, longi_empty
  );
endinterface

// File: rtl/lieat_wb_arbiter.sv
// rtl/lieat_wb_arbiter.sv - regfile write-port arbiter for EXU, LSU and in-order long-latency results
module lieat_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int RGIDX_SIZE = 5,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst,
  lieat_wb_arbiter_if.slave bus
);
  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {SRC_NONE, SRC_EXU, SRC_LSU, SRC_LONGI} src_e;

  logic [RGIDX_SIZE-1:0] q_rd [LQ_DEPTH];
  logic [XLEN-1:0]       q_pc [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   q_vld;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;
  logic                  q_empty, q_full, push, pop, longi_req, starved;
  src_e                  sel;

  logic                  nxt_en;
  logic [RGIDX_SIZE-1:0] nxt_rd;
  logic [XLEN-1:0]       nxt_data, nxt_pc;
  logic                  rs1_q_hit, rs2_q_hit, rs1_wb_hit, rs2_wb_hit;

  assign q_empty   = (count == '0);
  assign q_full    = (count == CW'(LQ_DEPTH));
  assign longi_req = bus.longi_wb_valid & ~q_empty;
  assign starved   = longi_req & (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    sel = SRC_NONE;
    if (starved)                 sel = SRC_LONGI;
    else if (bus.lsu_wb_valid)   sel = SRC_LSU;
    else if (longi_req)          sel = SRC_LONGI;
    else if (bus.exu_wb_valid)   sel = SRC_EXU;
  end

  assign bus.exu_wb_ready      = (sel == SRC_EXU);
  assign bus.lsu_wb_ready      = (sel == SRC_LSU);
  assign bus.longi_wb_ready    = (sel == SRC_LONGI);
  assign bus.longi_issue_ready = ~q_full;
  assign bus.longi_empty       = q_empty;

  // A full queue never accepts, even if the head retires this cycle.
  assign push = bus.longi_issue_valid & ~q_full;
  assign pop  = (sel == SRC_LONGI);

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr] <= bus.longi_issue_rd;
      q_pc[wr_ptr] <= bus.longi_issue_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A request against an empty queue is not a real request, so the count holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || !bus.longi_wb_valid) begin
      starve_cnt <= '0;
    end else if (longi_req && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_comb begin
    nxt_en   = 1'b0;
    nxt_rd   = '0;
    nxt_data = '0;
    nxt_pc   = '0;
    case (sel)
      SRC_EXU: begin
        nxt_en   = bus.exu_wb_en;
        nxt_rd   = bus.exu_wb_rd;
        nxt_data = bus.exu_wb_data;
        nxt_pc   = bus.exu_wb_pc;
      end
      SRC_LSU: begin
        nxt_en   = bus.lsu_wb_en;
        nxt_rd   = bus.lsu_wb_rd;
        nxt_data = bus.lsu_wb_data;
        nxt_pc   = bus.lsu_wb_pc;
      end
      SRC_LONGI: begin
        nxt_en   = 1'b1;
        nxt_rd   = q_rd[rd_ptr];
        nxt_data = bus.longi_wb_data;
        nxt_pc   = q_pc[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_valid <= 1'b0;
      bus.wb_en    <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      bus.wb_pc    <= '0;
      bus.wb_lsu   <= 1'b0;
    end else begin
      bus.wb_valid <= (sel != SRC_NONE);
      bus.wb_en    <= (sel != SRC_NONE) & nxt_en & (nxt_rd != '0);
      bus.wb_lsu   <= (sel == SRC_LSU);
      if (sel != SRC_NONE) begin
        bus.wb_rd   <= nxt_rd;
        bus.wb_data <= nxt_data;
        bus.wb_pc   <= nxt_pc;
      end
    end
  end

  always_comb begin
    rs1_q_hit = 1'b0;
    rs2_q_hit = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (q_vld[i] && (q_rd[i] == bus.exu_rs1)) rs1_q_hit = 1'b1;
      if (q_vld[i] && (q_rd[i] == bus.exu_rs2)) rs2_q_hit = 1'b1;
    end
  end

  assign rs1_wb_hit = bus.wb_valid & bus.wb_en & (bus.wb_rd == bus.exu_rs1);
  assign rs2_wb_hit = bus.wb_valid & bus.wb_en & (bus.wb_rd == bus.exu_rs2);

  assign bus.exu_rs1_busy = (bus.exu_rs1 != '0) & (rs1_q_hit | rs1_wb_hit);
  assign bus.exu_rs2_busy = (bus.exu_rs2 != '0) & (rs2_q_hit | rs2_wb_hit);
endmodule

// File: tb/tb_lieat_wb_arbiter.sv
// tb/tb_lieat_wb_arbiter.sv - directed bench for lieat_wb_arbiter
module tb_lieat_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lieat_wb_arbiter_if #(.XLEN(32), .RGIDX_SIZE(5)) bus ();

  lieat_wb_arbiter #(
    .XLEN(32), .RGIDX_SIZE(5), .LQ_DEPTH(4), .STARVE_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.exu_wb_valid      = 1'b0;
    bus.exu_wb_en         = 1'b0;
    bus.exu_wb_rd         = '0;
    bus.exu_wb_data       = '0;
    bus.exu_wb_pc         = '0;
    bus.lsu_wb_valid      = 1'b0;
    bus.lsu_wb_en         = 1'b0;
    bus.lsu_wb_rd         = '0;
    bus.lsu_wb_data       = '0;
    bus.lsu_wb_pc         = '0;
    bus.longi_issue_valid = 1'b0;
    bus.longi_issue_rd    = '0;
    bus.longi_issue_pc    = '0;
    bus.longi_wb_valid    = 1'b0;
    bus.longi_wb_data     = '0;
    bus.exu_rs1           = '0;
    bus.exu_rs2           = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.exu_rs1 = 5'd7;
    #1;
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_pc", bus.wb_pc, 32'd0);
    chk("rst_wb_lsu", 32'(bus.wb_lsu), 32'd0);
    chk("rst_longi_empty", 32'(bus.longi_empty), 32'd1);
    chk("rst_rs1_busy", 32'(bus.exu_rs1_busy), 32'd0);
    chk("rst_issue_ready", 32'(bus.longi_issue_ready), 32'd1);

    // EXU single write
    bus.exu_wb_valid = 1'b1; bus.exu_wb_en = 1'b1; bus.exu_wb_rd = 5'd5;
    bus.exu_wb_data = 32'h1234; bus.exu_wb_pc = 32'h8000_0000;
    #1;
    chk("exu_ready", 32'(bus.exu_wb_ready), 32'd1);
    tick();
    bus.exu_wb_valid = 1'b0;
    chk("exu_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("exu_wb_en", 32'(bus.wb_en), 32'd1);
    chk("exu_wb_rd", 32'(bus.wb_rd), 32'd5);
    chk("exu_wb_data", bus.wb_data, 32'h1234);
    chk("exu_wb_pc", bus.wb_pc, 32'h8000_0000);
    chk("exu_wb_lsu", 32'(bus.wb_lsu), 32'd0);
    tick();
    chk("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("idle_wb_en", 32'(bus.wb_en), 32'd0);
    chk("idle_wb_rd_hold", 32'(bus.wb_rd), 32'd5);

    // LSU beats EXU
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_en = 1'b1; bus.lsu_wb_rd = 5'd3;
    bus.lsu_wb_data = 32'h33; bus.lsu_wb_pc = 32'h200;
    bus.exu_wb_valid = 1'b1; bus.exu_wb_en = 1'b1; bus.exu_wb_rd = 5'd4;
    bus.exu_wb_data = 32'h44; bus.exu_wb_pc = 32'h204;
    #1;
    chk("pri_lsu_ready", 32'(bus.lsu_wb_ready), 32'd1);
    chk("pri_exu_wait", 32'(bus.exu_wb_ready), 32'd0);
    tick();
    bus.lsu_wb_valid = 1'b0;
    chk("pri_lsu_rd", 32'(bus.wb_rd), 32'd3);
    chk("pri_lsu_flag", 32'(bus.wb_lsu), 32'd1);
    chk("pri_lsu_data", bus.wb_data, 32'h33);
    #1;
    chk("pri_exu_ready", 32'(bus.exu_wb_ready), 32'd1);
    tick();
    bus.exu_wb_valid = 1'b0;
    chk("pri_exu_valid", 32'(bus.wb_valid), 32'd1);
    chk("pri_exu_rd", 32'(bus.wb_rd), 32'd4);
    chk("pri_exu_flag", 32'(bus.wb_lsu), 32'd0);
    tick();

    // single long instruction and scoreboard
    bus.longi_issue_valid = 1'b1; bus.longi_issue_rd = 5'd7; bus.longi_issue_pc = 32'h100;
    bus.exu_rs1 = 5'd7;
    #1;
    chk("li_issue_ready", 32'(bus.longi_issue_ready), 32'd1);
    chk("li_busy_before_push", 32'(bus.exu_rs1_busy), 32'd0);
    tick();
    bus.longi_issue_valid = 1'b0;
    #1;
    chk("li_not_empty", 32'(bus.longi_empty), 32'd0);
    chk("li_busy_queued", 32'(bus.exu_rs1_busy), 32'd1);
    bus.longi_wb_valid = 1'b1; bus.longi_wb_data = 32'hDEAD;
    #1;
    chk("li_wb_ready", 32'(bus.longi_wb_ready), 32'd1);
    tick();
    bus.longi_wb_valid = 1'b0;
    chk("li_wb_rd", 32'(bus.wb_rd), 32'd7);
    chk("li_wb_pc", bus.wb_pc, 32'h100);
    chk("li_wb_data", bus.wb_data, 32'hDEAD);
    chk("li_wb_en", 32'(bus.wb_en), 32'd1);
    chk("li_busy_in_wb", 32'(bus.exu_rs1_busy), 32'd1);
    chk("li_empty_after", 32'(bus.longi_empty), 32'd1);
    tick();
    chk("li_busy_cleared", 32'(bus.exu_rs1_busy), 32'd0);

    // long result on empty queue is ignored
    bus.longi_wb_valid = 1'b1; bus.exu_wb_valid = 1'b1; bus.exu_wb_rd = 5'd2;
    #1;
    chk("empty_longi_ready", 32'(bus.longi_wb_ready), 32'd0);
    chk("empty_exu_ready", 32'(bus.exu_wb_ready), 32'd1);
    tick();
    bus.longi_wb_valid = 1'b0; bus.exu_wb_valid = 1'b0;

    // starvation under continuous LSU traffic
    bus.longi_issue_valid = 1'b1; bus.longi_issue_rd = 5'd9; bus.longi_issue_pc = 32'h300;
    tick();
    bus.longi_issue_valid = 1'b0;
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_en = 1'b1; bus.lsu_wb_rd = 5'd1;
    bus.lsu_wb_data = 32'h11; bus.lsu_wb_pc = 32'h500;
    bus.longi_wb_valid = 1'b1; bus.longi_wb_data = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("starve_deny", 32'(bus.longi_wb_ready), 32'd0);
      chk("starve_lsu_ready", 32'(bus.lsu_wb_ready), 32'd1);
      tick();
    end
    bus.longi_issue_valid = 1'b1; bus.longi_issue_rd = 5'd10; bus.longi_issue_pc = 32'h304;
    #1;
    chk("starve_win", 32'(bus.longi_wb_ready), 32'd1);
    chk("starve_lsu_blocked", 32'(bus.lsu_wb_ready), 32'd0);
    tick();
    bus.longi_issue_valid = 1'b0;
    chk("starve_wb_rd", 32'(bus.wb_rd), 32'd9);
    chk("starve_wb_pc", bus.wb_pc, 32'h300);
    chk("starve_wb_data", bus.wb_data, 32'hBEEF);
    chk("starve_wb_lsu", 32'(bus.wb_lsu), 32'd0);
    #1;
    chk("starve_reset_deny", 32'(bus.longi_wb_ready), 32'd0);
    tick();
    bus.lsu_wb_valid = 1'b0;
    #1;
    chk("starve_normal_grant", 32'(bus.longi_wb_ready), 32'd1);
    tick();
    bus.longi_wb_valid = 1'b0;
    chk("starve_second_rd", 32'(bus.wb_rd), 32'd10);
    chk("starve_second_pc", bus.wb_pc, 32'h304);

    // fill, reject when full, then wrap with push+pop
    for (int i = 0; i < 4; i++) begin
      bus.longi_issue_valid = 1'b1;
      bus.longi_issue_rd = 5'(11 + i);
      bus.longi_issue_pc = 32'(32'h400 + 4 * i);
      #1;
      chk("fill_ready", 32'(bus.longi_issue_ready), 32'd1);
      tick();
    end
    bus.longi_issue_rd = 5'd30; bus.longi_issue_pc = 32'hFFF;
    #1;
    chk("full_not_ready", 32'(bus.longi_issue_ready), 32'd0);
    tick();
    bus.longi_issue_valid = 1'b0;
    bus.longi_wb_valid = 1'b1; bus.longi_wb_data = 32'hA0;
    #1;
    chk("full_pop_ready", 32'(bus.longi_wb_ready), 32'd1);
    tick();
    chk("wrap_rd_0", 32'(bus.wb_rd), 32'd11);
    chk("wrap_pc_0", bus.wb_pc, 32'h400);
    chk("wrap_data_0", bus.wb_data, 32'hA0);
    for (int k = 0; k < 8; k++) begin
      bus.longi_issue_valid = 1'b1;
      bus.longi_issue_rd = 5'(15 + k);
      bus.longi_issue_pc = 32'(32'h410 + 4 * k);
      bus.longi_wb_data = 32'(32'hA1 + k);
      #1;
      chk("wrap_issue_ready", 32'(bus.longi_issue_ready), 32'd1);
      tick();
      chk("wrap_rd", 32'(bus.wb_rd), 32'(12 + k));
      chk("wrap_pc", bus.wb_pc, 32'(32'h404 + 4 * k));
      chk("wrap_data", bus.wb_data, 32'(32'hA1 + k));
    end
    bus.longi_issue_valid = 1'b0;
    for (int j = 9; j < 12; j++) begin
      bus.longi_wb_data = 32'(32'hA0 + j);
      tick();
      chk("drain_rd", 32'(bus.wb_rd), 32'(11 + j));
      chk("drain_pc", bus.wb_pc, 32'(32'h400 + 4 * j));
    end
    bus.longi_wb_valid = 1'b0;
    #1;
    chk("drain_empty", 32'(bus.longi_empty), 32'd1);

    // rd=0 write, rs=0 query, reset with queued entries
    bus.exu_wb_valid = 1'b1; bus.exu_wb_en = 1'b1; bus.exu_wb_rd = 5'd0;
    bus.exu_wb_data = 32'h55; bus.exu_wb_pc = 32'h700;
    tick();
    bus.exu_wb_valid = 1'b0;
    chk("rd0_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("rd0_wb_en", 32'(bus.wb_en), 32'd0);
    bus.longi_issue_valid = 1'b1; bus.longi_issue_rd = 5'd0; bus.longi_issue_pc = 32'h600;
    tick();
    bus.longi_issue_rd = 5'd6; bus.longi_issue_pc = 32'h604;
    tick();
    bus.longi_issue_valid = 1'b0;
    bus.exu_rs1 = 5'd0; bus.exu_rs2 = 5'd6;
    #1;
    chk("rs0_busy", 32'(bus.exu_rs1_busy), 32'd0);
    chk("rs6_busy", 32'(bus.exu_rs2_busy), 32'd1);
    chk("pre_rst_not_empty", 32'(bus.longi_empty), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(bus.longi_empty), 32'd1);
    chk("mid_rst_busy", 32'(bus.exu_rs2_busy), 32'd0);
    chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("mid_rst_issue_ready", 32'(bus.longi_issue_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
